// File: rtl/alu_exec_unit.sv
// Handshaked EX-stage ALU: folds ALUOp/Funct decode into a registered result stage,
// with an iterative shift-add unsigned multiply taking WIDTH cycles.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUCtr,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  typedef enum logic [3:0] {
    CTR_AND   = 4'd0,
    CTR_OR    = 4'd1,
    CTR_ADD   = 4'd2,
    CTR_SUB   = 4'd6,
    CTR_SLT   = 4'd7,
    CTR_MULTU = 4'd8,
    CTR_NOR   = 4'd12,
    CTR_ILL   = 4'd15
  } ctr_e;

  typedef enum logic {IDLE, MUL} state_e;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state, state_nxt;
  ctr_e             ctr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, accept, is_mul, mul_done;

  always_comb begin
    ctr = CTR_ILL;
    case (ALUOp)
      2'b00: ctr = CTR_ADD;
      2'b01: ctr = CTR_SUB;
      2'b10: begin
        case (Funct)
          6'b100000: ctr = CTR_ADD;
          6'b100010: ctr = CTR_SUB;
          6'b100100: ctr = CTR_AND;
          6'b100101: ctr = CTR_OR;
          6'b101010: ctr = CTR_SLT;
          6'b100111: ctr = CTR_NOR;
          6'b011001: ctr = MUL_EN ? CTR_MULTU : CTR_ILL;
          default:   ctr = CTR_ILL;
        endcase
      end
      default: ctr = CTR_ILL;
    endcase
  end

  assign sum  = BusA + BusB;
  assign diff = BusA - BusB;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctr)
      CTR_ADD: begin
        alu_res = sum;
        alu_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      CTR_SUB: begin
        alu_res = diff;
        alu_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      CTR_AND: alu_res = BusA & BusB;
      CTR_OR:  alu_res = BusA | BusB;
      CTR_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      CTR_NOR: alu_res = ~(BusA | BusB);
      default: alu_res = '0;
    endcase
  end

  assign is_mul   = (ctr == CTR_MULTU);
  assign accept   = InValid && InReady;
  assign mul_done = (state == MUL) && (cnt == CW'(1));
  // Final partial product folds straight into Result on the last MUL edge.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (mul_done)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    InReady = (state == IDLE) && (!OutValid || OutReady);
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      OutValid <= 1'b0;
      Result   <= '0;
      ALUCtr   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else if (accept && is_mul) begin
        mcand  <= BusA;
        mplier <= BusB;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end

      if (mul_done) begin
        OutValid <= 1'b1;
        Result   <= acc_step;
        ALUCtr   <= CTR_MULTU;
        Zero     <= (acc_step == '0);
        Overflow <= 1'b0;
        Illegal  <= 1'b0;
      end else if (accept && !is_mul) begin
        OutValid <= 1'b1;
        Result   <= alu_res;
        ALUCtr   <= ctr;
        Zero     <= (alu_res == '0);
        Overflow <= alu_ovf;
        Illegal  <= (ctr == CTR_ILL);
      end else if (OutValid && OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: transaction-level reference model checked every cycle,
// directed literal cases, then randomized traffic; a MUL_EN=0 twin covers illegal multu.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         Clk = 1'b0, Reset_L = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic [1:0]   ALUOp = '0;
  logic [5:0]   Funct = '0;
  logic [W-1:0] BusA = '0, BusB = '0;

  logic         InReady, OutValid, Zero, Overflow, Illegal;
  logic [W-1:0] Result;
  logic [3:0]   ALUCtr;
  logic         z_InReady, z_OutValid, z_Zero, z_Overflow, z_Illegal;
  logic [W-1:0] z_Result;
  logic [3:0]   z_ALUCtr;

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady),
    .ALUOp(ALUOp), .Funct(Funct), .BusA(BusA), .BusB(BusB),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result), .ALUCtr(ALUCtr),
    .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
  );

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .Clk(Clk), .Reset_L(Reset_L), .InValid(InValid), .InReady(z_InReady),
    .ALUOp(ALUOp), .Funct(Funct), .BusA(BusA), .BusB(BusB),
    .OutValid(z_OutValid), .OutReady(OutReady), .Result(z_Result), .ALUCtr(z_ALUCtr),
    .Zero(z_Zero), .Overflow(z_Overflow), .Illegal(z_Illegal)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   ctr;
    logic         zero;
    logic         ovf;
    logic         ill;
    logic         is_mul;
  } ref_t;

  // Reference semantics from the opcode table, using wide integer arithmetic.
  function automatic ref_t ref_op(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    ref_t r;
    int kind;
    longint sa, sb, s;
    logic [63:0] p;
    r = '0;
    kind = -1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) kind = 0;
    else if (op == 2'b01) kind = 1;
    else if (op == 2'b10) begin
      case (fn)
        6'b100000: kind = 0;
        6'b100010: kind = 1;
        6'b100100: kind = 2;
        6'b100101: kind = 3;
        6'b101010: kind = 4;
        6'b100111: kind = 5;
        6'b011001: kind = 6;
        default:   kind = -1;
      endcase
    end
    case (kind)
      0: begin s = sa + sb; r.res = s[W-1:0]; r.ctr = 4'd2; r.ovf = (s > SMAX) || (s < SMIN); end
      1: begin s = sa - sb; r.res = s[W-1:0]; r.ctr = 4'd6; r.ovf = (s > SMAX) || (s < SMIN); end
      2: begin r.res = a & b; r.ctr = 4'd0; end
      3: begin r.res = a | b; r.ctr = 4'd1; end
      4: begin r.res = (sa < sb) ? 32'd1 : 32'd0; r.ctr = 4'd7; end
      5: begin r.res = ~(a | b); r.ctr = 4'd12; end
      6: begin p = {32'd0, a} * {32'd0, b}; r.res = p[W-1:0]; r.ctr = 4'd8; r.is_mul = 1'b1; end
      default: begin r.res = '0; r.ctr = 4'd15; r.ill = 1'b1; end
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  // Timing model: a multiply occupies the unit for W edges, everything else one.
  int   m_busy = 0;
  bit   m_ov   = 1'b0;
  ref_t m_out  = '0;
  ref_t m_pend = '0;

  always @(posedge Clk or negedge Reset_L) begin
    bit   ready, load;
    ref_t nr;
    if (!Reset_L) begin
      m_busy = 0;
      m_ov   = 1'b0;
      m_out  = '0;
      m_pend = '0;
    end else begin
      ready = (m_busy == 0) && (!m_ov || OutReady);
      load  = 1'b0;
      nr    = '0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin load = 1'b1; nr = m_pend; end
      end else if (InValid && ready) begin
        nr = ref_op(ALUOp, Funct, BusA, BusB);
        if (nr.is_mul) begin m_busy = W; m_pend = nr; end
        else load = 1'b1;
      end
      if (load) begin m_ov = 1'b1; m_out = nr; end
      else if (m_ov && OutReady) m_ov = 1'b0;
    end
  end

  always @(negedge Clk) begin
    check("cyc_InReady",  InReady,  (m_busy == 0) && (!m_ov || OutReady));
    check("cyc_OutValid", OutValid, m_ov);
    check("cyc_Result",   Result,   m_out.res);
    check("cyc_ALUCtr",   ALUCtr,   m_out.ctr);
    check("cyc_Zero",     Zero,     m_out.zero);
    check("cyc_Overflow", Overflow, m_out.ovf);
    check("cyc_Illegal",  Illegal,  m_out.ill);
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    InValid = 1'b1; ALUOp = op; Funct = fn; BusA = a; BusB = b;
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] res, input logic [3:0] ctr);
    check({name, "_valid"},  OutValid, 1'b1);
    check({name, "_result"}, Result,   res);
    check({name, "_ctr"},    ALUCtr,   ctr);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] fn_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b100111, 6'b011001, 6'b000000};

  initial begin
    #22 Reset_L = 1'b1;
    #1;
    check("ready_after_reset", InReady, 1'b1);
    check("no_valid_after_reset", OutValid, 1'b0);
    @(posedge Clk); #1;
    OutReady = 1'b1;

    issue(2'b10, 6'b100000, 32'hC, 32'hA); expect_out("sweep_add", 32'h16, 4'd2);
    issue(2'b10, 6'b100010, 32'hC, 32'hA); expect_out("sweep_sub", 32'h2, 4'd6);
    issue(2'b10, 6'b100100, 32'hC, 32'hA); expect_out("sweep_and", 32'h8, 4'd0);
    issue(2'b10, 6'b100101, 32'hC, 32'hA); expect_out("sweep_or", 32'hE, 4'd1);
    issue(2'b10, 6'b101010, 32'hC, 32'hA); expect_out("sweep_slt", 32'h0, 4'd7);
    issue(2'b10, 6'b100111, 32'hC, 32'hA); expect_out("sweep_nor", 32'hFFFF_FFF1, 4'd12);
    issue(2'b01, 6'b000000, 32'd5, 32'd5);
    check("beq_zero", Zero, 1'b1);

    issue(2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1);
    expect_out("add_ovf", 32'h8000_0000, 4'd2);
    check("add_ovf_flag", Overflow, 1'b1);
    issue(2'b01, 6'b000000, 32'h8000_0000, 32'd1);
    expect_out("sub_ovf", 32'h7FFF_FFFF, 4'd6);
    check("sub_ovf_flag", Overflow, 1'b1);
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    expect_out("slt_neg", 32'd1, 4'd7);

    issue(2'b10, 6'b011001, 32'h0001_2345, 32'h0000_0100);
    check("nomul_valid",   z_OutValid, 1'b1);
    check("nomul_illegal", z_Illegal,  1'b1);
    check("nomul_ctr",     z_ALUCtr,   4'd15);
    check("nomul_result",  z_Result,   32'd0);
    check("nomul_zero",    z_Zero,     1'b1);
    check("nomul_ovf",     z_Overflow, 1'b0);
    check("nomul_ready",   z_InReady,  1'b1);
    for (int i = 1; i < W; i++) begin
      @(posedge Clk); #1;
      check("mul_busy_ready", InReady, 1'b0);
    end
    @(posedge Clk); #1;
    expect_out("multu", 32'h0123_4500, 4'd8);

    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (W) @(posedge Clk);
    #1;
    expect_out("multu_max", 32'h0000_0001, 4'd8);

    issue(2'b10, 6'b011001, 32'd3, 32'd5);
    repeat (10) @(posedge Clk);
    #2 Reset_L = 1'b0;
    #1;
    check("rst_valid",   OutValid, 1'b0);
    check("rst_result",  Result,   32'd0);
    check("rst_ctr",     ALUCtr,   4'd0);
    check("rst_zero",    Zero,     1'b0);
    check("rst_ovf",     Overflow, 1'b0);
    check("rst_illegal", Illegal,  1'b0);
    @(posedge Clk); #1;
    Reset_L = 1'b1;
    #1;
    check("rst_release_ready", InReady, 1'b1);
    repeat (W + 4) @(posedge Clk);
    #1;
    check("rst_no_stale", OutValid, 1'b0);

    OutReady = 1'b0;
    issue(2'b00, 6'b000000, 32'd10, 32'd20);
    repeat (5) begin
      @(posedge Clk); #1;
      check("bp_ready", InReady, 1'b0);
      expect_out("bp_hold", 32'd30, 4'd2);
    end
    OutReady = 1'b1;
    issue(2'b10, 6'b100010, 32'd50, 32'd8);
    expect_out("bp_swap", 32'd42, 4'd6);

    issue(2'b11, 6'b100000, 32'd7, 32'd9);
    expect_out("ill_aluop", 32'd0, 4'd15);
    check("ill_aluop_flag", Illegal, 1'b1);
    check("ill_aluop_zero", Zero, 1'b1);
    issue(2'b10, 6'b000000, 32'd7, 32'd9);
    expect_out("ill_funct", 32'd0, 4'd15);
    check("ill_funct_flag", Illegal, 1'b1);

    repeat (3000) begin
      @(posedge Clk); #1;
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      ALUOp    = 2'($urandom);
      Funct    = fn_tab[$urandom_range(0, 7)];
      if (Funct == 6'b000000) Funct = 6'($urandom);
      BusA     = pick();
      BusB     = pick();
    end
    @(posedge Clk); #1;
    InValid  = 1'b0;
    OutReady = 1'b1;
    repeat (W + 4) @(posedge Clk);
    #1;
    check("drain_idle", InReady, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
